recirc_scheduler: RTL and testbench
===================================

RECIRC_SCHEDULER -- requirements
Module: recirc_scheduler

Interface
REQ-001 Parameter DATA_W, default 32, data word width.
REQ-002 Parameter WARMUP, default 4, consecutive active-high cycles required before forwarding; legal range 1..15.
REQ-003 clk_2f  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 active  input  1  link-active indication; 1 = words may be forwarded.
REQ-006 req_valid  input  4  per-lane request; lane i has a word on req_data[i*DATA_W +: DATA_W].
REQ-007 req_data  input  4*DATA_W  concatenated lane words, lane 0 in the LSBs.
REQ-008 ack  output  4  combinational one-hot pop strobe to the granted lane; all zero when no grant.
REQ-009 valid_out  output  1  registered forwarded-word valid.
REQ-010 data_out  output  DATA_W  registered forwarded word.
REQ-011 lane_out  output  2  registered lane index of data_out.
REQ-012 recirc_valid  output  1  registered recirculated-word valid.
REQ-013 recirc_data  output  DATA_W  registered recirculated word.
REQ-014 recirc_lane  output  2  registered lane index of recirc_data.
REQ-015 state_out  output  2  current FSM state (IDLE=0, WARM=1, FWD=2).
REQ-016 fwd_cnt, recirc_cnt  output  8 each  saturating counts of forwarded and recirculated words.

Function
REQ-017 Every cycle with any req_valid bit set, exactly one lane is granted and ack asserts for that lane only.
REQ-018 Grant is round-robin: search starts at lane ptr, ptr+1, ... mod 4; after a grant to lane g, ptr becomes (g+1) mod 4; ptr is unchanged when nothing is granted.
REQ-019 Granted word appears on the output registers one cycle after its ack (latency 1).
REQ-020 In FWD, the granted word drives valid_out/data_out/lane_out; recirc_valid = 0.
REQ-021 In IDLE or WARM, the granted word drives recirc_valid/recirc_data/recirc_lane; valid_out = 0.
REQ-022 With no grant, valid_out = 0 and recirc_valid = 0 next cycle; data_out/recirc_data/lane fields hold their previous values.
REQ-023 FSM: IDLE -> WARM when active = 1; WARM -> FWD when warm counter reaches WARMUP-1 with active = 1; WARM -> IDLE when active = 0 (counter cleared); FWD -> IDLE when active = 0.
REQ-024 Routing of a grant uses the state in the cycle of the ack, not the state one cycle later; a word acked in the cycle active falls is still forwarded.
REQ-025 fwd_cnt increments on each valid_out = 1, recirc_cnt on each recirc_valid = 1; both saturate at 255 and never wrap.
REQ-026 No word is lost or duplicated: every ack produces exactly one of valid_out or recirc_valid on the next cycle.

Reset
REQ-027 reset sampled high at a rising edge: state = IDLE, ptr = 0, warm counter = 0, valid_out = 0, recirc_valid = 0, data_out = 0, recirc_data = 0, lane_out = 0, recirc_lane = 0, fwd_cnt = 0, recirc_cnt = 0.
REQ-028 While reset is high, ack = 0 regardless of req_valid.
REQ-029 Reset asserted mid-operation overrides any grant or transition in that cycle; a word presented during reset is not acked and remains pending.

Structure
REQ-030 Shared package holds the state enumeration (IDLE, WARM, FWD), NUM_LANES = 4, and LANE_W = 2.
REQ-031 Round-robin grant logic is one sub-module, rr_arbiter_4 (inputs req[3:0], ptr[1:0]; outputs one-hot grant, grant index, any-grant flag); pointer register stays in recirc_scheduler.

Verification
REQ-032 Reset, active = 0, req_valid = 4'b1111 for 4 cycles -> ack 0001, 0010, 0100, 1000; recirc_lane 0,1,2,3 one cycle later; valid_out = 0; recirc_cnt = 4.
REQ-033 WARMUP = 4, active rises at cycle 10 and stays high -> state WARM cycles 11-13, FWD from cycle 14; first forwarded word on valid_out at cycle 15.
REQ-034 In FWD, req_valid = 4'b0101 constant -> grants alternate lane 0, lane 2; lane 1 and 3 never acked.
REQ-035 In FWD, active drops in the same cycle lane 3 is acked with data 0xDEADBEEF -> next cycle valid_out = 1, data_out = 0xDEADBEEF, lane_out = 3; state IDLE.
REQ-036 active = 0 with a request every cycle for 300 cycles -> recirc_cnt stops at 255, no wrap.
REQ-037 reset pulsed one cycle while in FWD with req_valid = 4'b0010 -> ack = 0 that cycle, all outputs zero next cycle, state IDLE, lane 1 acked on the following cycle.

Source files
------------

// File: rtl/recirc_scheduler_pkg.sv
// Shared types and widths for the recirculating lane scheduler.
package recirc_scheduler_pkg;
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;
  localparam int CNT_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    FWD  = 2'd2
  } state_t;
endpackage

// File: rtl/recirc_scheduler_arb.sv
// Four-lane round-robin arbiter: search starts at ptr and wraps, first requester wins.
module rr_arbiter_4
  import recirc_scheduler_pkg::*;
(
  input  logic [NUM_LANES-1:0] req,
  input  logic [LANE_W-1:0]    ptr,
  output logic [NUM_LANES-1:0] grant,
  output logic [LANE_W-1:0]    grant_idx,
  output logic                 any_grant
);

  logic [LANE_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx = ptr + LANE_W'(i);
      if (req[idx] && !any_grant) begin
        any_grant      = 1'b1;
        grant_idx      = idx;
        grant[idx]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/recirc_scheduler.sv
// Round-robin lane scheduler: granted words are forwarded once the link has been
// active for WARMUP cycles, otherwise they are handed back on the recirculation port.
module recirc_scheduler
  import recirc_scheduler_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WARMUP = 4
)
(
  input  logic                        clk_2f,
  input  logic                        reset,
  input  logic                        active,
  input  logic [NUM_LANES-1:0]        req_valid,
  input  logic [NUM_LANES*DATA_W-1:0] req_data,
  output logic [NUM_LANES-1:0]        ack,
  output logic                        valid_out,
  output logic [DATA_W-1:0]           data_out,
  output logic [LANE_W-1:0]           lane_out,
  output logic                        recirc_valid,
  output logic [DATA_W-1:0]           recirc_data,
  output logic [LANE_W-1:0]           recirc_lane,
  output logic [1:0]                  state_out,
  output logic [CNT_W-1:0]            fwd_cnt,
  output logic [CNT_W-1:0]            recirc_cnt
);

  localparam logic [3:0] WARM_LAST = 4'(WARMUP - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
  endfunction

  state_t              state;
  logic [3:0]          warm_cnt;
  logic [LANE_W-1:0]   ptr;
  logic [NUM_LANES-1:0] grant;
  logic [LANE_W-1:0]   grant_idx;
  logic                any_grant;
  logic [DATA_W-1:0]   lane_word [NUM_LANES];
  logic [DATA_W-1:0]   sel_word;

  rr_arbiter_4 u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_word[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign sel_word  = lane_word[grant_idx];
  // Reset suppresses the pop so a word offered during reset stays pending.
  assign ack       = reset ? '0 : grant;
  assign state_out = state;

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state        <= IDLE;
      warm_cnt     <= '0;
      ptr          <= '0;
      valid_out    <= 1'b0;
      data_out     <= '0;
      lane_out     <= '0;
      recirc_valid <= 1'b0;
      recirc_data  <= '0;
      recirc_lane  <= '0;
      fwd_cnt      <= '0;
      recirc_cnt   <= '0;
    end else begin
      fwd_cnt      <= sat_inc(fwd_cnt, valid_out);
      recirc_cnt   <= sat_inc(recirc_cnt, recirc_valid);
      // Routing follows the state seen in the ack cycle, not the next one.
      valid_out    <= any_grant && (state == FWD);
      recirc_valid <= any_grant && (state != FWD);
      if (any_grant) begin
        ptr <= grant_idx + 1'b1;
        if (state == FWD) begin
          data_out <= sel_word;
          lane_out <= grant_idx;
        end else begin
          recirc_data <= sel_word;
          recirc_lane <= grant_idx;
        end
      end

      // warm_cnt counts consecutive active cycles, including the one that left IDLE.
      case (state)
        IDLE: begin
          if (active) begin
            state    <= WARM;
            warm_cnt <= 4'd1;
          end
        end
        WARM: begin
          if (!active) begin
            state    <= IDLE;
            warm_cnt <= '0;
          end else if (warm_cnt >= WARM_LAST) begin
            state <= FWD;
          end else begin
            warm_cnt <= warm_cnt + 1'b1;
          end
        end
        FWD: begin
          if (!active) begin
            state    <= IDLE;
            warm_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          warm_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_recirc_scheduler.sv
// Directed and randomized bench for recirc_scheduler against a cycle-level reference model.
module tb_recirc_scheduler;
  localparam int DATA_W = 32;
  localparam int WARMUP = 4;
  localparam int WMIN   = (WARMUP < 2) ? 2 : WARMUP;

  logic                clk_2f = 1'b0;
  logic                reset;
  logic                active;
  logic [3:0]          req_valid;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          ack;
  logic                valid_out;
  logic [DATA_W-1:0]   data_out;
  logic [1:0]          lane_out;
  logic                recirc_valid;
  logic [DATA_W-1:0]   recirc_data;
  logic [1:0]          recirc_lane;
  logic [1:0]          state_out;
  logic [7:0]          fwd_cnt;
  logic [7:0]          recirc_cnt;

  always #5 clk_2f = ~clk_2f;

  recirc_scheduler #(.DATA_W(DATA_W), .WARMUP(WARMUP)) dut (
    .clk_2f       (clk_2f),
    .reset        (reset),
    .active       (active),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .ack          (ack),
    .valid_out    (valid_out),
    .data_out     (data_out),
    .lane_out     (lane_out),
    .recirc_valid (recirc_valid),
    .recirc_data  (recirc_data),
    .recirc_lane  (recirc_lane),
    .state_out    (state_out),
    .fwd_cnt      (fwd_cnt),
    .recirc_cnt   (recirc_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: link state derived from the run length of active cycles.
  int              m_ptr    = 0;
  int              m_streak = 0;
  int              m_fcnt   = 0;
  int              m_rcnt   = 0;
  logic            m_vo     = 1'b0;
  logic            m_rv     = 1'b0;
  logic [DATA_W-1:0] m_do   = '0;
  logic [DATA_W-1:0] m_rd   = '0;
  logic [1:0]      m_lo     = '0;
  logic [1:0]      m_rl     = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    int g = -1;
    for (int k = 0; k < 4; k++) begin
      if (g < 0 && r[(p + k) % 4]) g = (p + k) % 4;
    end
    return g;
  endfunction

  function automatic int exp_state();
    if (m_streak == 0) return 0;
    if (m_streak < WMIN) return 1;
    return 2;
  endfunction

  function automatic logic [4*DATA_W-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    int g;
    int st;
    @(negedge clk_2f);
    g  = pick(req_valid, m_ptr);
    st = exp_state();
    check("ack", 64'(ack), (reset || g < 0) ? 64'd0 : (64'd1 << g));
    check("state", 64'(state_out), 64'(st));
    check("valid_out", 64'(valid_out), 64'(m_vo));
    check("data_out", 64'(data_out), 64'(m_do));
    check("lane_out", 64'(lane_out), 64'(m_lo));
    check("recirc_valid", 64'(recirc_valid), 64'(m_rv));
    check("recirc_data", 64'(recirc_data), 64'(m_rd));
    check("recirc_lane", 64'(recirc_lane), 64'(m_rl));
    check("fwd_cnt", 64'(fwd_cnt), 64'(m_fcnt));
    check("recirc_cnt", 64'(recirc_cnt), 64'(m_rcnt));
    @(posedge clk_2f);
    if (reset) begin
      m_ptr = 0; m_streak = 0; m_fcnt = 0; m_rcnt = 0;
      m_vo = 1'b0; m_rv = 1'b0; m_do = '0; m_rd = '0; m_lo = '0; m_rl = '0;
    end else begin
      if (m_vo && m_fcnt < 255) m_fcnt++;
      if (m_rv && m_rcnt < 255) m_rcnt++;
      if (g >= 0) begin
        if (st == 2) begin
          m_vo = 1'b1; m_rv = 1'b0;
          m_do = req_data[g*DATA_W +: DATA_W];
          m_lo = 2'(g);
        end else begin
          m_rv = 1'b1; m_vo = 1'b0;
          m_rd = req_data[g*DATA_W +: DATA_W];
          m_rl = 2'(g);
        end
        m_ptr = (g + 1) % 4;
      end else begin
        m_vo = 1'b0;
        m_rv = 1'b0;
      end
      m_streak = active ? m_streak + 1 : 0;
    end
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    active    = 1'b0;
    req_valid = 4'b1111;
    req_data  = rnd_data();
    repeat (2) @(posedge clk_2f);
    #1;
    tick();
    tick();

    // Link down: all four lanes rotate onto the recirculation port.
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_data = rnd_data();
      tick();
    end
    req_valid = 4'b0000;
    tick();
    check("rr_recirc_cnt4", 64'(recirc_cnt), 64'd4);
    check("rr_last_lane", 64'(recirc_lane), 64'd3);
    check("rr_no_fwd", 64'(fwd_cnt), 64'd0);

    // Warm-up: four consecutive active cycles reach FWD.
    active = 1'b1;
    repeat (3) tick();
    check("warm_state", 64'(state_out), 64'd1);
    tick();
    check("fwd_state", 64'(state_out), 64'd2);

    req_valid = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      req_data = rnd_data();
      tick();
    end

    // Lane 3 acked in the same cycle active falls is still forwarded.
    req_valid = 4'b1000;
    req_data  = rnd_data();
    req_data[3*DATA_W +: DATA_W] = 32'hDEADBEEF;
    active    = 1'b0;
    tick();
    check("drop_valid_out", 64'(valid_out), 64'd1);
    check("drop_data_out", 64'(data_out), 64'hDEADBEEF);
    check("drop_lane_out", 64'(lane_out), 64'd3);
    check("drop_recirc_valid", 64'(recirc_valid), 64'd0);
    check("drop_state", 64'(state_out), 64'd0);
    req_valid = 4'b0000;
    tick();

    // Recirculation counter saturation.
    for (int i = 0; i < 300; i++) begin
      req_valid = 4'($urandom_range(1, 15));
      req_data  = rnd_data();
      tick();
    end
    check("recirc_cnt_sat", 64'(recirc_cnt), 64'd255);

    // Reset pulse while forwarding.
    req_valid = 4'b0000;
    active    = 1'b1;
    repeat (5) tick();
    check("pre_reset_fwd", 64'(state_out), 64'd2);
    req_valid = 4'b0010;
    req_data  = rnd_data();
    reset     = 1'b1;
    tick();
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_recirc_valid", 64'(recirc_valid), 64'd0);
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_recirc_cnt", 64'(recirc_cnt), 64'd0);
    check("rst_state", 64'(state_out), 64'd0);
    reset = 1'b0;
    tick();
    check("post_rst_recirc_lane", 64'(recirc_lane), 64'd1);
    check("post_rst_recirc_valid", 64'(recirc_valid), 64'd1);

    // Randomized traffic with long active runs and occasional resets.
    req_valid = 4'b0000;
    tick();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) active = ~active;
      reset     = ($urandom_range(0, 63) == 0);
      req_valid = 4'($urandom());
      req_data  = rnd_data();
      tick();
    end
    reset     = 1'b0;
    req_valid = 4'b0000;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
